// File: rtl/capture_seq_if.sv
// Handshake bundle between capture_seq and its neighbours (capture, trigger and cmd_cfg logic).
// The master drives the strobes and configuration; the slave is capture_seq itself.
interface capture_seq_if #(
  parameter int AW = 9,
  parameter int PW = 16
);
  logic          wrt_smpl;
  logic          run;
  logic          mode;
  logic [PW-1:0] trig_pos;
  logic          triggered;
  logic          capture_done;
  logic          we;
  logic [AW-1:0] waddr;
  logic          armed;
  logic          set_capture_done;
  logic [AW-1:0] trig_addr;
  logic          busy;
  logic          auto_trig;

  modport master (
    output wrt_smpl, run, mode, trig_pos, triggered, capture_done,
    input  we, waddr, armed, set_capture_done, trig_addr, busy, auto_trig
  );

  modport slave (
    input  wrt_smpl, run, mode, trig_pos, triggered, capture_done,
    output we, waddr, armed, set_capture_done, trig_addr, busy, auto_trig
  );
endinterface

// File: rtl/capture_seq.sv
// Capture controller for the logic-analyzer sample RAM: circular write addressing, pre/post-trigger fill.
// Optional macro AUTO_TRIG_EN adds a forced trigger after AUTO_TMO armed samples.
module capture_seq #(
  parameter int ENTRIES  = 384,
  parameter int AW       = $clog2(ENTRIES),
  parameter int PW       = 16,
  parameter int AUTO_TMO = 1024
) (
  input logic         clk,
  input logic         rst,
  capture_seq_if.slave bus
);

  typedef logic [AW-1:0] addr_t;
  typedef logic [AW:0]   cnt_t;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] PRE   = 3'd1;
  localparam logic [2:0] ARMED = 3'd2;
  localparam logic [2:0] POST  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam cnt_t  LAST_CNT  = cnt_t'(ENTRIES - 1);
  localparam addr_t LAST_ADDR = addr_t'(ENTRIES - 1);

  logic [2:0]    state;
  logic [2:0]    next_state;
  addr_t         waddr;
  addr_t         trig_addr;
  cnt_t          eff_pos;
  cnt_t          pre_cnt;
  cnt_t          post_cnt;
  cnt_t          sat_pos;
  cnt_t          pre_need;
  cnt_t          pre_inc;
  cnt_t          post_inc;
  logic          armed;
  logic          busy;
  logic          set_done;
  logic          active;
  logic          we;
  logic          reinit;
  logic          trig_hit;
  logic          forced;
  logic [PW-1:0] trig_pos_in;
  logic [31:0]   trig_pos_wide;

  assign trig_pos_in   = bus.trig_pos;
  assign trig_pos_wide = 32'(trig_pos_in);
  assign sat_pos       = (trig_pos_wide > 32'(ENTRIES - 1)) ? LAST_CNT : cnt_t'(trig_pos_wide);
  assign pre_need      = LAST_CNT - eff_pos;
  assign pre_inc       = pre_cnt + 1'b1;
  assign post_inc      = post_cnt + 1'b1;
  assign active        = (state == PRE) || (state == ARMED) || (state == POST);
  assign we            = bus.wrt_smpl & active;

`ifdef AUTO_TRIG_EN
  localparam int TW = $clog2(AUTO_TMO + 1);
  typedef logic [TW-1:0] tmo_t;

  tmo_t tmo;
  logic auto_trig_q;

  assign forced = bus.wrt_smpl && !bus.triggered && (tmo == tmo_t'(AUTO_TMO - 1));

  // tmo counts armed samples only, so it restarts every time ARMED is entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo         <= '0;
      auto_trig_q <= 1'b0;
    end else begin
      if (state != ARMED)
        tmo <= '0;
      else if (bus.wrt_smpl)
        tmo <= tmo + 1'b1;
      if (reinit)
        auto_trig_q <= 1'b0;
      else if (state == ARMED && bus.run && trig_hit)
        auto_trig_q <= forced;
    end
  end

  assign bus.auto_trig = auto_trig_q;
`else
  assign forced        = 1'b0;
  assign bus.auto_trig = 1'b0;
`endif

  assign trig_hit = bus.wrt_smpl && (bus.triggered || forced);

  // Dropping run always wins over progress, so an abort never reaches DONE
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (bus.run) next_state = (sat_pos == LAST_CNT) ? ARMED : PRE;
      PRE: begin
        if (!bus.run)                                next_state = IDLE;
        else if (bus.wrt_smpl && pre_inc == pre_need) next_state = ARMED;
      end
      ARMED: begin
        if (!bus.run)     next_state = IDLE;
        else if (trig_hit) next_state = (eff_pos == '0) ? DONE : POST;
      end
      POST: begin
        if (!bus.run)                                 next_state = IDLE;
        else if (bus.wrt_smpl && post_inc == eff_pos) next_state = DONE;
      end
      DONE: begin
        if (!set_done && !bus.capture_done)
          next_state = (bus.run && bus.mode) ? ((sat_pos == LAST_CNT) ? ARMED : PRE) : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign reinit = ((state == IDLE) || (state == DONE)) &&
                  ((next_state == PRE) || (next_state == ARMED));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      waddr     <= '0;
      trig_addr <= '0;
      eff_pos   <= '0;
      pre_cnt   <= '0;
      post_cnt  <= '0;
      armed     <= 1'b0;
      busy      <= 1'b0;
      set_done  <= 1'b0;
    end else begin
      state    <= next_state;
      armed    <= (next_state == ARMED);
      busy     <= (next_state == PRE) || (next_state == ARMED) || (next_state == POST);
      set_done <= (next_state == DONE) && (state != DONE);

      if (reinit) begin
        waddr    <= '0;
        pre_cnt  <= '0;
        post_cnt <= '0;
        eff_pos  <= sat_pos;
      end else begin
        if (we)
          waddr <= (waddr == LAST_ADDR) ? '0 : waddr + 1'b1;
        if (state == PRE && bus.wrt_smpl)
          pre_cnt <= pre_inc;
        if (state == POST && bus.wrt_smpl)
          post_cnt <= post_inc;
        if (state == ARMED && bus.run && trig_hit) begin
          trig_addr <= waddr;
          post_cnt  <= '0;
        end
      end
    end
  end

  assign bus.we               = we;
  assign bus.waddr            = waddr;
  assign bus.armed            = armed;
  assign bus.set_capture_done = set_done;
  assign bus.trig_addr        = trig_addr;
  assign bus.busy             = busy;

endmodule

// File: tb/tb_capture_seq.sv
// Randomized bench for capture_seq: expectations come from write-count bookkeeping of the capture rules.
module tb_capture_seq;
  localparam int ENTRIES  = 384;
  localparam int AW       = $clog2(ENTRIES);
  localparam int PW       = 16;
  localparam int AUTO_TMO = 8;
`ifdef AUTO_TRIG_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   vectors    = 0;
  int   miscompares = 0;

  capture_seq_if #(.AW(AW), .PW(PW)) bus ();

  capture_seq #(.ENTRIES(ENTRIES), .AW(AW), .PW(PW), .AUTO_TMO(AUTO_TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running, want finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // One whole capture. Everything expected is derived from how many samples have been written (n):
  // pre_need samples fill, the trigger is sample k, then eff_pos more samples, then the done pulse.
  task automatic do_capture(input string name, input int tp, input int k_off, input int wr_pct,
                            input bit m, input int abort_at, input bit drop_run_after);
    int eff, pre_need, k, total, n, cyc;
    bit exp_auto, wr, trg, aborted;
    logic [3:0] exp_flags, obs_flags;
    eff      = (tp > ENTRIES - 1) ? ENTRIES - 1 : tp;
    pre_need = ENTRIES - 1 - eff;
    k        = pre_need + k_off;
    exp_auto = 1'b0;
    if (AUTO && k_off > AUTO_TMO - 1) begin
      k        = pre_need + AUTO_TMO - 1;
      exp_auto = 1'b1;
    end
    total = k + 1 + eff;

    @(negedge clk);
    bus.run          = 1'b1;
    bus.mode         = m;
    bus.trig_pos     = tp[PW-1:0];
    bus.capture_done = 1'b0;
    bus.wrt_smpl     = 1'($urandom_range(0, 1));
    bus.triggered    = 1'($urandom_range(0, 1));
    #1;
    vectors++;
    if ({bus.we, bus.busy, bus.set_capture_done} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL %s.start: got we/busy/scd=%b, want 000", name, {bus.we, bus.busy, bus.set_capture_done});
    end
    @(posedge clk);

    n = 0; cyc = 0; aborted = 1'b0;
    while (n < total && !aborted) begin
      @(negedge clk);
      wr = ($urandom_range(1, 100) <= wr_pct);
      if (abort_at >= 0 && n == abort_at) begin
        bus.run = 1'b0;
        wr      = 1'b1;
        aborted = 1'b1;
      end
      if (n >= pre_need && n <= k && wr)
        trg = (n == k) && !exp_auto;
      else
        trg = 1'($urandom_range(0, 1));
      bus.wrt_smpl  = wr;
      bus.triggered = trg;
      #1;
      exp_flags = {wr, (n >= pre_need && n <= k), 1'b1, 1'b0};
      obs_flags = {bus.we, bus.armed, bus.busy, bus.set_capture_done};
      vectors++;
      if (obs_flags !== exp_flags) begin
        miscompares++;
        $display("[TB] FAIL %s.flags n=%0d: got we/armed/busy/scd=%b, want %b", name, n, obs_flags, exp_flags);
      end
      vectors++;
      if (bus.waddr !== AW'(n % ENTRIES)) begin
        miscompares++;
        $display("[TB] FAIL %s.waddr n=%0d: got %0d, want %0d", name, n, bus.waddr, n % ENTRIES);
      end
      @(posedge clk);
      if (wr) n++;
      cyc++;
      if (cyc > 20000) begin
        miscompares++;
        $display("[TB] FAIL %s.timeout: got %0d writes, want %0d", name, n, total);
        return;
      end
    end

    if (aborted) begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        bus.wrt_smpl  = 1'($urandom_range(0, 1));
        bus.triggered = 1'($urandom_range(0, 1));
        #1;
        vectors++;
        if ({bus.we, bus.armed, bus.busy, bus.set_capture_done} !== 4'b0000 || bus.waddr !== AW'(n % ENTRIES)) begin
          miscompares++;
          $display("[TB] FAIL %s.abort: got we/armed/busy/scd=%b waddr=%0d, want 0000 waddr=%0d",
                   name, {bus.we, bus.armed, bus.busy, bus.set_capture_done}, bus.waddr, n % ENTRIES);
        end
      end
      return;
    end

    @(negedge clk);
    bus.wrt_smpl  = 1'b1;
    bus.triggered = 1'($urandom_range(0, 1));
    #1;
    vectors++;
    if ({bus.we, bus.armed, bus.busy, bus.set_capture_done} !== 4'b0001) begin
      miscompares++;
      $display("[TB] FAIL %s.done_pulse: got we/armed/busy/scd=%b, want 0001", name,
               {bus.we, bus.armed, bus.busy, bus.set_capture_done});
    end
    vectors++;
    if (bus.waddr !== AW'(total % ENTRIES)) begin
      miscompares++;
      $display("[TB] FAIL %s.final_waddr: got %0d, want %0d", name, bus.waddr, total % ENTRIES);
    end
    vectors++;
    if (bus.trig_addr !== AW'(k % ENTRIES)) begin
      miscompares++;
      $display("[TB] FAIL %s.trig_addr: got %0d, want %0d", name, bus.trig_addr, k % ENTRIES);
    end
    vectors++;
    if (bus.auto_trig !== exp_auto) begin
      miscompares++;
      $display("[TB] FAIL %s.auto_trig: got %b, want %b", name, bus.auto_trig, exp_auto);
    end
    bus.capture_done = 1'b1;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.wrt_smpl = 1'($urandom_range(0, 1));
      #1;
      vectors++;
      if ({bus.we, bus.busy, bus.set_capture_done} !== 3'b000 || bus.waddr !== AW'(total % ENTRIES)) begin
        miscompares++;
        $display("[TB] FAIL %s.done_hold: got we/busy/scd=%b waddr=%0d, want 000 waddr=%0d",
                 name, {bus.we, bus.busy, bus.set_capture_done}, bus.waddr, total % ENTRIES);
      end
    end

    if (drop_run_after) begin
      @(negedge clk);
      bus.run          = 1'b0;
      bus.capture_done = 1'b0;
      @(negedge clk);
      #1;
      vectors++;
      if ({bus.we, bus.busy, bus.set_capture_done} !== 3'b000) begin
        miscompares++;
        $display("[TB] FAIL %s.idle: got we/busy/scd=%b, want 000", name, {bus.we, bus.busy, bus.set_capture_done});
      end
    end
  endtask

  task automatic test_reset();
    rst              = 1'b1;
    bus.wrt_smpl     = 1'b1;
    bus.run          = 1'b0;
    bus.mode         = 1'b0;
    bus.trig_pos     = '0;
    bus.triggered    = 1'b0;
    bus.capture_done = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if ({bus.we, bus.armed, bus.busy, bus.set_capture_done, bus.auto_trig} !== 5'b0 ||
        bus.waddr !== '0 || bus.trig_addr !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset: got flags=%b waddr=%0d trig_addr=%0d, want all 0",
               {bus.we, bus.armed, bus.busy, bus.set_capture_done, bus.auto_trig}, bus.waddr, bus.trig_addr);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    do_capture("basic", 100, 117, 100, 1'b0, -1, 1'b1);
  endtask

  task automatic test_saturation();
    do_capture("sat_pos", 16'hFFFF, 0, 100, 1'b0, -1, 1'b1);
    do_capture("zero_pos", 0, 0, 100, 1'b0, -1, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 3; i++)
      do_capture("random", int'($urandom_range(0, 500)), int'($urandom_range(0, 20)), 60, 1'b0, -1, 1'b1);
  endtask

  task automatic test_back_to_back();
    do_capture("rearm1", 100, 5, 70, 1'b1, -1, 1'b0);
    do_capture("rearm2", 100, 5, 70, 1'b1, -1, 1'b1);
  endtask

  task automatic test_abort();
    do_capture("abort_post", 50, 3, 80, 1'b0, 357, 1'b0);
    do_capture("abort_last", 50, 3, 80, 1'b0, 386, 1'b0);
  endtask

  task automatic test_async_reset();
    do_capture("pre_rst", 20, 2, 100, 1'b0, -1, 1'b1);
    @(negedge clk);
    bus.run      = 1'b1;
    bus.trig_pos = 16'd100;
    bus.wrt_smpl = 1'b1;
    repeat (10) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({bus.we, bus.armed, bus.busy, bus.set_capture_done, bus.auto_trig} !== 5'b0 ||
        bus.waddr !== '0 || bus.trig_addr !== '0) begin
      miscompares++;
      $display("[TB] FAIL async_reset: got flags=%b waddr=%0d trig_addr=%0d, want all 0",
               {bus.we, bus.armed, bus.busy, bus.set_capture_done, bus.auto_trig}, bus.waddr, bus.trig_addr);
    end
    @(negedge clk);
    bus.run = 1'b0;
    rst     = 1'b0;
  endtask

  task automatic test_auto_trig();
    do_capture("auto_force", 200, 50, 100, 1'b0, -1, 1'b1);
    do_capture("auto_real", 200, 7, 100, 1'b0, -1, 1'b1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_random();
    test_back_to_back();
    test_abort();
    test_async_reset();
    test_auto_trig();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
